// File: rtl/prog_counter_pkg.sv
// prog_counter_pkg: shared states and direction encodings for the programmable counter
package prog_counter_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} cnt_state_t;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/prog_counter_clk_prescaler.sv
// clk_prescaler: enable-gated divider issuing one tick every prescale+1 enabled cycles
module clk_prescaler #(
   parameter int PRE_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [PRE_W-1:0] prescale,
   output logic             tick
);

   logic [PRE_W-1:0] pre_cnt;

   // >= so a prescale lowered below the running count still ticks at once
   assign tick = en && (pre_cnt >= prescale);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         pre_cnt <= '0;
      else if (clr)
         pre_cnt <= '0;
      else if (en)
         pre_cnt <= tick ? '0 : pre_cnt + 1'b1;

endmodule

// File: rtl/prog_counter.sv
// prog_counter: modulo up/down counter with prescaler, load/clear and one-shot FSM
module prog_counter
   import prog_counter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int PRE_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dir,
   input  logic             oneshot,
   input  logic             start,
   input  logic [WIDTH-1:0] limit,
   input  logic [PRE_W-1:0] prescale,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             busy
);

   cnt_state_t       state, state_d;
   logic [WIDTH-1:0] count_d, step_val;
   logic             tick, start_go, counting, wrap, tc_d, busy_d;

   clk_prescaler #(.PRE_W(PRE_W)) u_pre (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .clr      (clr || load || start_go),
      .prescale (prescale),
      .tick     (tick)
   );

   always_comb begin
      start_go = oneshot && start && en && (state != RUN);
      counting = !oneshot || (state == RUN);
      wrap     = (dir == DIR_UP) ? (count >= limit) : (count == '0);
      step_val = (dir == DIR_UP) ? (wrap ? '0 : count + 1'b1)
               : (wrap ? limit : ((count > limit) ? limit : count - 1'b1));
      count_d  = count;
      tc_d     = 1'b0;
      state_d  = state;
      if (clr) begin
         count_d = '0;
         state_d = IDLE;
      end else if (load)
         count_d = load_val;
      else if (start_go) begin
         count_d = (dir == DIR_UP) ? '0 : limit;
         state_d = RUN;
      end else if (tick && counting) begin
         count_d = step_val;
         tc_d    = wrap;
         if (oneshot && wrap)
            state_d = DONE;
      end
      // free-run parks the FSM so re-entering one-shot always waits for start
      if (!oneshot)
         state_d = IDLE;
      busy_d = oneshot ? (state_d == RUN) : en;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         count <= '0;
         tc    <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_d;
         count <= count_d;
         tc    <= tc_d;
         busy  <= busy_d;
      end

endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: directed scenarios plus random traffic against an arithmetic reference model
module tb_prog_counter;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       en = 1'b0, clr = 1'b0, load = 1'b0, dir = 1'b1, oneshot = 1'b0, start = 1'b0;
   logic [7:0] load_val = '0, limit = '0;
   logic [3:0] prescale = '0;
   logic [7:0] count;
   logic       tc, busy;

   int n_chk = 0, n_pass = 0;
   int m_cnt = 0, m_pre = 0, m_ph = 0;
   bit m_tc = 0, m_busy = 0;

   always #5 clk = ~clk;

   prog_counter #(.WIDTH(8), .PRE_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
      .dir(dir), .oneshot(oneshot), .start(start), .limit(limit), .prescale(prescale),
      .count(count), .tc(tc), .busy(busy)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
   endtask

   // m_ph: 0 idle, 1 running, 2 finished; counting as modular arithmetic over 0..lim
   task automatic model();
      bit tk, go, run, ntc;
      int lim, nc, ph;
      lim = int'(limit);
      tk  = en && (m_pre >= int'(prescale));
      go  = oneshot && start && en && (m_ph != 1);
      run = !oneshot || (m_ph == 1);
      nc  = m_cnt;
      ntc = 0;
      ph  = m_ph;
      m_pre = (clr || load || go) ? 0 : (en ? (tk ? 0 : m_pre + 1) : m_pre);
      if (clr) begin
         nc = 0;
         ph = 0;
      end else if (load) nc = int'(load_val);
      else if (go) begin
         nc = dir ? 0 : lim;
         ph = 1;
      end else if (tk && run) begin
         if (dir) begin
            nc  = (m_cnt > lim) ? 0 : (m_cnt + 1) % (lim + 1);
            ntc = (nc == 0);
         end else begin
            nc  = (m_cnt > lim) ? lim : (m_cnt + lim) % (lim + 1);
            ntc = (m_cnt == 0);
         end
         if (oneshot && ntc) ph = 2;
      end
      if (!oneshot) ph = 0;
      m_cnt  = nc;
      m_tc   = ntc;
      m_ph   = ph;
      m_busy = oneshot ? (ph == 1) : en;
   endtask

   task automatic cycle();
      model();
      @(posedge clk);
      #1;
      chk("count", int'(count), m_cnt);
      chk("tc", int'(tc), int'(m_tc));
      chk("busy", int'(busy), int'(m_busy));
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_count", int'(count), 0);
      chk("rst_tc", int'(tc), 0);
      chk("rst_busy", int'(busy), 0);
      m_cnt = 0; m_pre = 0; m_ph = 0; m_tc = 0; m_busy = 0;
      @(negedge clk) rst_n = 1'b1;
   endtask

   initial begin
      int seq1[6] = '{1, 2, 3, 4, 5, 0};
      int tcs, busys, first;
      #2;
      chk("rst_count", int'(count), 0);
      chk("rst_tc", int'(tc), 0);
      chk("rst_busy", int'(busy), 0);
      @(negedge clk) rst_n = 1'b1;

      // free-run up, limit 5
      limit = 8'd5; prescale = 4'd0; en = 1'b1; dir = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cycle();
         chk("s1_count", int'(count), seq1[i]);
         chk("s1_tc", int'(tc), (i == 5) ? 1 : 0);
      end

      // free-run down, limit 3, tick every 3rd cycle
      clr = 1'b1; cycle(); clr = 1'b0;
      limit = 8'd3; prescale = 4'd2; dir = 1'b0; tcs = 0;
      for (int i = 1; i <= 15; i++) begin
         cycle();
         tcs += int'(tc);
         if (i % 3 == 0) chk("s2_count", int'(count), (i == 15) ? 3 : 3 - (i / 3 - 1));
      end
      chk("s2_tcs", tcs, 2);

      // one-shot up, limit 4, stray start while running
      oneshot = 1'b1; dir = 1'b1; limit = 8'd4; prescale = 4'd0;
      cycle();
      start = 1'b1; tcs = 0; busys = 0;
      for (int i = 0; i < 9; i++) begin
         cycle();
         start = (i == 1);
         tcs += int'(tc);
         busys += int'(busy);
      end
      chk("s3_busy_cycles", busys, 5);
      chk("s3_tcs", tcs, 1);
      chk("s3_final", int'(count), 0);

      // load above limit, then clr+load together
      oneshot = 1'b0; limit = 8'd10; load = 1'b1; load_val = 8'd200;
      cycle(); load = 1'b0;
      chk("s4_loaded", int'(count), 200);
      cycle();
      chk("s4_wrap", int'(count), 0);
      chk("s4_wrap_tc", int'(tc), 1);
      cycle(); cycle();
      clr = 1'b1; load = 1'b1;
      cycle(); clr = 1'b0; load = 1'b0;
      chk("s4_clr_count", int'(count), 0);
      chk("s4_clr_tc", int'(tc), 0);

      // en low mid-prescale stretches the tick
      prescale = 4'd3; clr = 1'b1; cycle(); clr = 1'b0;
      first = 0;
      for (int i = 1; i <= 8; i++) begin
         en = !(i == 2 || i == 3);
         cycle();
         if (first == 0 && count != 8'd0) first = i;
      end
      en = 1'b1;
      chk("s5_tick_edge", first, 6);

      // async reset in the middle of a one-shot run
      oneshot = 1'b1; limit = 8'd20; prescale = 4'd0; clr = 1'b1; cycle(); clr = 1'b0;
      start = 1'b1; cycle(); start = 1'b0;
      for (int i = 0; i < 7; i++) cycle();
      chk("s6_pre_count", int'(count), 7);
      do_reset();
      for (int i = 0; i < 4; i++) cycle();
      chk("s6_idle_count", int'(count), 0);
      chk("s6_idle_busy", int'(busy), 0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         en    = ($urandom_range(0, 9) != 0);
         clr   = ($urandom_range(0, 49) == 0);
         load  = ($urandom_range(0, 39) == 0);
         start = ($urandom_range(0, 9) == 0);
         load_val = 8'($urandom);
         if ($urandom_range(0, 19) == 0) dir = ~dir;
         if ($urandom_range(0, 39) == 0) oneshot = ~oneshot;
         if ($urandom_range(0, 59) == 0)
            limit = $urandom_range(0, 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
         if ($urandom_range(0, 49) == 0)
            prescale = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom);
         if ($urandom_range(0, 299) == 0) do_reset();
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
